// File: rtl/input_group_unpack_pkg.sv
// Shared types and helpers for the input-side unpack path toward the PIM macro.
package input_group_unpack_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } unpack_state_e;

  localparam int BYTES_PER_WORD = 4;

  localparam logic MODE_BYTE = 1'b0;
  localparam logic MODE_WORD = 1'b1;

  // Per-byte zero-point removal with 8-bit wrap (no saturation).
  function automatic logic [31:0] sub_zero_point(input logic [31:0] word, input logic [7:0] zp);
    logic [31:0] res;
    res = 32'h0000_0000;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      res[8*i +: 8] = word[8*i +: 8] - zp;
    end
    return res;
  endfunction

endpackage

// File: rtl/input_group_unpack_if.sv
// Beat handshake toward the macro input driver.
interface input_group_unpack_if;
  logic        macro_valid_o;
  logic [31:0] macro_data_o;
  logic [1:0]  byte_idx_o;
  logic        last_o;
  logic        macro_ready_i;

  modport master (
    output macro_valid_o, macro_data_o, byte_idx_o, last_o,
    input  macro_ready_i
  );

  modport slave (
    input  macro_valid_o, macro_data_o, byte_idx_o, last_o,
    output macro_ready_i
  );
endinterface

// File: rtl/input_group_unpack_sync_word_fifo.sv
// Synchronous word FIFO; the extra count bit separates full from empty.
module sync_word_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign rdata     = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/input_group_unpack.sv
// Unpacks buffered store words into zero-point corrected byte or word beats.
module input_group_unpack
  import input_group_unpack_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 store_en_i,
  input  logic [31:0]          data_i,
  input  logic                 mode_i,
  input  logic                 zero_point_en_i,
  input  logic [7:0]           zero_point_i,
  input  logic                 flush_i,
  input_group_unpack_if.master macro,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 overflow_o
);
  unpack_state_e state_r;
  logic [31:0]   word_r;
  logic [7:0]    zp_r;
  logic [1:0]    byte_idx_r;
  logic          valid_r;
  logic [31:0]   data_r;
  logic          last_r;
  logic          overflow_r;

  logic [31:0]   fifo_rdata_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          pop_s;
  logic          handshake_s;
  logic [31:0]   head_s;
  logic [1:0]    next_idx_s;

  sync_word_fifo #(.DEPTH(DEPTH), .WIDTH(32), .CNT_W(CNT_W)) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .flush (flush_i),
    .push  (store_en_i && !flush_i),
    .pop   (pop_s),
    .wdata (data_i),
    .rdata (fifo_rdata_s),
    .count (count_o),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign handshake_s = valid_r && macro.macro_ready_i;
  assign head_s      = sub_zero_point(fifo_rdata_s, zp_r);
  assign next_idx_s  = byte_idx_r + 2'd1;

  // Pop from IDLE, or chain straight from the last beat of the current word.
  always_comb begin
    pop_s = 1'b0;
    if (flush_i) begin
      pop_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    pop_s = !fifo_empty_s;
        EMIT:    pop_s = handshake_s && last_r && !fifo_empty_s;
        default: pop_s = 1'b0;
      endcase
    end
  end

  // Zero point survives flush; it is sampled only at pop time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      zp_r <= 8'h00;
    end else if (zero_point_en_i) begin
      zp_r <= zero_point_i;
    end else begin
      zp_r <= zp_r;
    end
  end

  // Sticky drop indicator.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_r <= 1'b0;
    end else if (flush_i) begin
      overflow_r <= 1'b0;
    end else if (store_en_i && fifo_full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Beat FSM with registered beat outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      word_r     <= 32'h0000_0000;
      byte_idx_r <= 2'd0;
      valid_r    <= 1'b0;
      data_r     <= 32'h0000_0000;
      last_r     <= 1'b0;
    end else if (flush_i) begin
      state_r    <= IDLE;
      word_r     <= 32'h0000_0000;
      byte_idx_r <= 2'd0;
      valid_r    <= 1'b0;
      data_r     <= 32'h0000_0000;
      last_r     <= 1'b0;
    end else if (pop_s) begin
      state_r    <= EMIT;
      word_r     <= head_s;
      byte_idx_r <= 2'd0;
      valid_r    <= 1'b1;
      if (mode_i == MODE_WORD) begin
        data_r <= head_s;
        last_r <= 1'b1;
      end else begin
        data_r <= {24'h00_0000, head_s[7:0]};
        last_r <= 1'b0;
      end
    end else if (state_r == EMIT && handshake_s && !last_r) begin
      byte_idx_r <= next_idx_s;
      data_r     <= {24'h00_0000, word_r[{next_idx_s, 3'b000} +: 8]};
      last_r     <= (next_idx_s == 2'(BYTES_PER_WORD - 1));
    end else if (state_r == EMIT && handshake_s) begin
      state_r    <= IDLE;
      byte_idx_r <= 2'd0;
      valid_r    <= 1'b0;
      data_r     <= 32'h0000_0000;
      last_r     <= 1'b0;
    end else begin
      state_r <= state_r;
    end
  end

  assign macro.macro_valid_o = valid_r;
  assign macro.macro_data_o  = data_r;
  assign macro.byte_idx_o    = byte_idx_r;
  assign macro.last_o        = last_r;
  assign full_o              = fifo_full_s;
  assign empty_o             = fifo_empty_s;
  assign overflow_o          = overflow_r;
endmodule

// File: tb/tb_input_group_unpack.sv
// Randomized self-checking bench for input_group_unpack against a beat-queue model.
module tb_input_group_unpack;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_ni;
  logic             store_en;
  logic [31:0]      data;
  logic             mode;
  logic             zp_en;
  logic [7:0]       zp;
  logic             flush;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             overflow;

  input_group_unpack_if bus ();

  input_group_unpack #(.DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .store_en_i      (store_en),
    .data_i          (data),
    .mode_i          (mode),
    .zero_point_en_i (zp_en),
    .zero_point_i    (zp),
    .flush_i         (flush),
    .macro           (bus),
    .full_o          (full),
    .empty_o         (empty),
    .count_o         (count),
    .overflow_o      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  idx;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int          checks;
  int          errors;
  bit          hold_pending;
  logic [31:0] hold_data;
  logic [1:0]  hold_idx;
  logic        hold_last;

  // Reference: byte minus zero point, modulo 256.
  function automatic logic [7:0] offset_byte(logic [7:0] b, logic [7:0] z);
    int v;
    v = int'(b) - int'(z);
    if (v < 0) v = v + 256;
    return v[7:0];
  endfunction

  function automatic void add_word(logic [31:0] w, bit m, logic [7:0] z);
    beat_t b;
    if (m) begin
      b.data = {offset_byte(w[31:24], z), offset_byte(w[23:16], z),
                offset_byte(w[15:8], z), offset_byte(w[7:0], z)};
      b.idx  = 2'd0;
      b.last = 1'b1;
      exp_q.push_back(b);
    end else begin
      for (int i = 0; i < 4; i++) begin
        b.data = {24'h0, offset_byte(w[8*i +: 8], z)};
        b.idx  = 2'(i);
        b.last = (i == 3);
        exp_q.push_back(b);
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_zp(logic [7:0] v);
    zp_en = 1'b1;
    zp    = v;
    step();
    zp_en = 1'b0;
  endtask

  // Per-cycle monitor: beat vs model, and hold stability while stalled.
  task automatic cycle_check();
    beat_t e;
    if (hold_pending) begin
      checks++;
      if (bus.macro_valid_o !== 1'b1 || bus.macro_data_o !== hold_data ||
          bus.byte_idx_o !== hold_idx || bus.last_o !== hold_last) begin
        errors++;
        $display("FAIL hold_stable: got v=%b d=%h i=%0d l=%b want v=1 d=%h i=%0d l=%b",
                 bus.macro_valid_o, bus.macro_data_o, bus.byte_idx_o, bus.last_o,
                 hold_data, hold_idx, hold_last);
      end
    end
    if (bus.macro_valid_o === 1'b1 && bus.macro_ready_i === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got d=%h want none", bus.macro_data_o);
      end else begin
        e = exp_q.pop_front();
        if (bus.macro_data_o !== e.data || bus.byte_idx_o !== e.idx || bus.last_o !== e.last) begin
          errors++;
          $display("FAIL beat: got d=%h i=%0d l=%b want d=%h i=%0d l=%b",
                   bus.macro_data_o, bus.byte_idx_o, bus.last_o, e.data, e.idx, e.last);
        end
      end
    end
    hold_pending = (bus.macro_valid_o === 1'b1) && (bus.macro_ready_i !== 1'b1);
    hold_data    = bus.macro_data_o;
    hold_idx     = bus.byte_idx_o;
    hold_last    = bus.last_o;
    step();
  endtask

  // pat: 0 ready high, 1 ready 1,0,0 repeating, 2 random.
  task automatic drain(int budget, int pat);
    for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
      case (pat)
        0:       bus.macro_ready_i = 1'b1;
        1:       bus.macro_ready_i = (c % 3 == 0);
        default: bus.macro_ready_i = 1'($urandom % 2);
      endcase
      cycle_check();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats left want 0", exp_q.size());
    end
    checks++;
    if (bus.macro_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_drain: got valid=%b want 0", bus.macro_valid_o);
    end
    bus.macro_ready_i = 1'b1;
    hold_pending = 0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
    checks++;
    if (bus.macro_valid_o !== 1'b0 || bus.macro_data_o !== 32'h0 || bus.byte_idx_o !== 2'd0 || bus.last_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_beat: got v=%b d=%h i=%0d l=%b want 0 0 0 0",
               bus.macro_valid_o, bus.macro_data_o, bus.byte_idx_o, bus.last_o);
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_fifo: got e=%b f=%b c=%0d o=%b want 1 0 0 0", empty, full, count, overflow);
    end
  endtask

  task automatic test_byte_mode();
    set_zp(8'h10);
    mode = 1'b0;
    bus.macro_ready_i = 1'b1;
    add_word(32'h4433_2211, 1'b0, 8'h10);
    store_en = 1'b1;
    data = 32'h4433_2211;
    step();
    store_en = 1'b0;
    checks++;
    if (bus.macro_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_t1: got valid=%b want 0", bus.macro_valid_o);
    end
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.macro_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL byte_valid%0d: got %b want 1", k, bus.macro_valid_o);
      end
      cycle_check();
    end
    checks++;
    if (bus.macro_valid_o !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL byte_end: got valid=%b left=%0d want 0 0", bus.macro_valid_o, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    set_zp(8'h05);
    mode = 1'b1;
    bus.macro_ready_i = 1'b1;
    add_word(32'h0003_0201, 1'b1, 8'h05);
    add_word(32'hFFFF_FFFF, 1'b1, 8'h05);
    store_en = 1'b1;
    data = 32'h0003_0201;
    step();
    data = 32'hFFFF_FFFF;
    step();
    store_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bus.macro_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL b2b_valid%0d: got %b want 1", k, bus.macro_valid_o);
      end
      cycle_check();
    end
    checks++;
    if (bus.macro_valid_o !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_end: got valid=%b left=%0d want 0 0", bus.macro_valid_o, exp_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    logic [7:0]  z;
    z = 8'($urandom);
    set_zp(z);
    mode = 1'b1;
    bus.macro_ready_i = 1'b0;
    hold_pending = 0;
    for (int i = 0; i < 10; i++) begin
      w = $urandom;
      store_en = 1'b1;
      data = w;
      if (i < 9) add_word(w, 1'b1, z);
      step();
      if (i >= 8) begin
        checks++;
        if (count !== CNT_W'(8) || full !== 1'b1 || overflow !== (i == 9)) begin
          errors++;
          $display("FAIL overflow_store%0d: got c=%0d f=%b o=%b want 8 1 %0d",
                   i + 1, count, full, overflow, (i == 9));
        end
      end
    end
    store_en = 1'b0;
    drain(100, 0);
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drained: got e=%b o=%b want 1 1", empty, overflow);
    end
  endtask

  task automatic test_ready_toggle();
    logic [31:0] w;
    logic [7:0]  z;
    z = 8'($urandom);
    set_zp(z);
    mode = 1'b0;
    bus.macro_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w = $urandom;
      add_word(w, 1'b0, z);
      store_en = 1'b1;
      data = w;
      step();
    end
    store_en = 1'b0;
    hold_pending = 0;
    drain(80, 1);
  endtask

  task automatic test_flush();
    bit found;
    set_zp(8'h33);
    mode = 1'b0;
    bus.macro_ready_i = 1'b1;
    hold_pending = 0;
    for (int i = 0; i < 2; i++) begin
      data = $urandom;
      add_word(data, 1'b0, 8'h33);
      store_en = 1'b1;
      cycle_check();
    end
    store_en = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (bus.macro_valid_o === 1'b1 && bus.byte_idx_o === 2'd2) found = 1;
      else cycle_check();
    end
    checks++;
    if (!found || overflow !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup: got found=%0d o=%b want 1 1", found, overflow);
    end
    flush = 1'b1;
    store_en = 1'b1;
    data = $urandom;
    step();
    flush = 1'b0;
    store_en = 1'b0;
    exp_q.delete();
    hold_pending = 0;
    checks++;
    if (bus.macro_valid_o !== 1'b0 || count !== '0 || empty !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: got v=%b c=%0d e=%b o=%b want 0 0 1 0",
               bus.macro_valid_o, count, empty, overflow);
    end
    step();
    mode = 1'b1;
    add_word(32'h0000_0000, 1'b1, 8'h33);
    store_en = 1'b1;
    data = 32'h0000_0000;
    step();
    store_en = 1'b0;
    drain(20, 0);
  endtask

  task automatic test_random();
    int n;
    int sent;
    logic [7:0] z;
    for (int r = 0; r < 10; r++) begin
      mode = 1'($urandom % 2);
      z = 8'($urandom);
      set_zp(z);
      n = $urandom_range(1, 9);
      sent = 0;
      for (int c = 0; c < 300 && sent < n; c++) begin
        store_en = 1'($urandom % 2);
        data = $urandom;
        bus.macro_ready_i = 1'($urandom % 2);
        if (store_en) begin
          add_word(data, mode, z);
          sent++;
        end
        cycle_check();
      end
      store_en = 1'b0;
      drain(300, 2);
    end
    checks++;
    if (overflow !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL random_end: got o=%b c=%0d want 0 0", overflow, count);
    end
  endtask

  task automatic test_reset_mid_word();
    mode = 1'b0;
    bus.macro_ready_i = 1'b0;
    store_en = 1'b1;
    data = $urandom;
    step();
    data = $urandom;
    step();
    store_en = 1'b0;
    step();
    rst_ni = 1'b0;
    #1;
    checks++;
    if (bus.macro_valid_o !== 1'b0 || bus.macro_data_o !== 32'h0 || count !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b d=%h c=%0d o=%b want 0 0 0 0",
               bus.macro_valid_o, bus.macro_data_o, count, overflow);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    step();
    exp_q.delete();
    hold_pending = 0;
  endtask

  initial begin
    clk = 1'b0;
    rst_ni = 1'b0;
    store_en = 1'b0;
    data = 32'h0;
    mode = 1'b0;
    zp_en = 1'b0;
    zp = 8'h00;
    flush = 1'b0;
    bus.macro_ready_i = 1'b0;
    checks = 0;
    errors = 0;
    hold_pending = 0;
    @(negedge clk);
    test_reset();
    test_byte_mode();
    test_back_to_back();
    test_overflow();
    test_ready_toggle();
    test_flush();
    test_random();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
